err_level_ctrl: RTL
===================

Name: err_level_ctrl

Overview:
Sequencer for the CP0 error-level machinery. It tracks Status.ERL and a one-deep nested-error level, and decides which EPC register captures the faulting PC: the ErrorEPC unit at the first level, the nested ErrorEPC unit at the second. It also sequences ERET returns and hands redirect requests to the pipeline through a valid/ack handshake. It sits in cp0 beside the two EPC units and drives their capture and write enables.

Parameters:
NEST_CNT_W, 2, width of the saturating diagnostic counter of nested errors.
RET_VEC, 2'b11, redir_code value used for ERET redirects.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
soft_rst_req  in  1  soft reset request from the pipeline (level)
nmi_req  in  1  NMI request (level)
cache_err_req  in  1  cache error request (level)
eret_req  in  1  ERET retiring (single-cycle pulse)
bd_in  in  1  faulting instruction is in a delay slot
sw_erl_we  in  1  mtc0 Status write strobe
sw_erl_data  in  1  ERL bit value being written by mtc0
redir_ack  in  1  pipeline accepted the redirect
erl  out  1  Status.ERL
nested_erl  out  1  nested-error level active
err_epc_cap  out  1  one-cycle capture strobe to the ErrorEPC unit
nested_epc_cap  out  1  one-cycle capture strobe to the nested ErrorEPC unit
cap_bd  out  1  registered bd_in, valid with either capture strobe
redir_valid  out  1  redirect pending
redir_code  out  2  0=reset, 1=NMI, 2=cache error, RET_VEC=ERET
ret_sel  out  1  ERET target: 0=ErrorEPC, 1=nested ErrorEPC
ev_stall  out  1  new events blocked (high while redir_valid is high)
nest_cnt  out  NEST_CNT_W  saturating count of nested errors

Behaviour:
- Reset: erl=1 (the architectural reset state); all other outputs 0; state=ERR.
- States:
  - NORM: erl=0, nested_erl=0.
  - ERR: erl=1, nested_erl=0.
  - NEST: erl=1, nested_erl=1.
- Event priority, when several requests are high in the same cycle: soft_rst_req > nmi_req > cache_err_req > eret_req.
- Events are sampled only when redir_valid=0. The one exception is soft_rst_req, which is always sampled.
- Accepting an exception event (reset, NMI or cache error) in the sampling cycle:
  - NORM: next cycle err_epc_cap=1 for exactly 1 cycle, state goes to ERR.
  - ERR: nested_epc_cap=1 for 1 cycle, state goes to NEST, nest_cnt increments and saturates at all-ones.
  - NEST: no capture strobe, state stays NEST, nest_cnt increments and saturates. The redirect is still issued.
  - In all cases cap_bd=bd_in as sampled; redir_valid=1 and redir_code=event, both in the same cycle as the strobe.
- soft_rst_req while redir_valid=1:
  - Overwrites redir_code with 0, with no new capture strobe.
  - Forces state ERR and clears nested_erl.
- eret_req while redir_valid=0:
  - NORM: ignored, no redirect.
  - ERR: next cycle state=NORM, redir_valid=1, redir_code=RET_VEC, ret_sel=0.
  - NEST: next cycle state=ERR, redir_valid=1, redir_code=RET_VEC, ret_sel=1.
- Handshake:
  - redir_valid, redir_code and ret_sel hold stable until the cycle in which redir_ack=1.
  - redir_valid drops the cycle after that ack.
  - An event can be sampled in that same ack cycle, so back-to-back redirects are allowed.
  - redir_ack while redir_valid=0 is ignored.
- Software ERL write, sw_erl_we=1 with no accepted event in that cycle:
  - data 0: state goes to NORM (also clears nested_erl).
  - data 1 from NORM: state goes to ERR.
  - data 1 otherwise: no change.
  - If an event or ERET is accepted in the same cycle, the software write is dropped.
- Requests are level-sensitive. A request held high re-fires once redir_valid drops, so the requester must deassert on ack.
- All outputs are registered, and capture strobes are never asserted together.

Test Plan:
1. Release rst with no requests: erl=1, nested_erl=0, no strobes. Then sw_erl_we=1 with sw_erl_data=0 -> erl=0 next cycle.
2. From NORM, cache_err_req=1 with bd_in=1:
   - next cycle err_epc_cap=1, cap_bd=1, redir_code=2, erl=1.
   - Hold redir_ack=0 for 3 cycles -> outputs stable.
   - redir_ack=1 -> redir_valid=0 next cycle.
3. From ERR, nmi_req=1:
   - nested_epc_cap=1, nested_erl=1, nest_cnt=1.
   - A second NMI in NEST -> no strobe, nest_cnt=2.
   - Two further NMIs -> nest_cnt stays at 3.
4. ERET from NEST -> ret_sel=1, state ERR. After ack, ERET -> ret_sel=0, erl=0. A third ERET -> no redir_valid.
5. nmi_req and cache_err_req high together -> redir_code=1. Then soft_rst_req while redirect pending -> redir_code becomes 0, no strobe, nested_erl=0.
6. Assert rst while redir_valid=1 in NEST -> all outputs to reset values immediately (asynchronous), erl=1. sw_erl_we together with eret_req in ERR -> ERET wins and erl=0 via the ERET path.

Source files
------------

// File: rtl/err_level_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : err_level_ctrl
// Brief    : CP0 error-level sequencer: ERL / nested ERL tracking, EPC capture
//            strobes, ERET sequencing and redirect valid/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
module err_level_ctrl #(
    parameter int         NEST_CNT_W = 2,
    parameter logic [1:0] RET_VEC    = 2'b11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  soft_rst_req,
    input  logic                  nmi_req,
    input  logic                  cache_err_req,
    input  logic                  eret_req,
    input  logic                  bd_in,
    input  logic                  sw_erl_we,
    input  logic                  sw_erl_data,
    input  logic                  redir_ack,
    output logic                  erl,
    output logic                  nested_erl,
    output logic                  err_epc_cap,
    output logic                  nested_epc_cap,
    output logic                  cap_bd,
    output logic                  redir_valid,
    output logic [1:0]            redir_code,
    output logic                  ret_sel,
    output logic                  ev_stall,
    output logic [NEST_CNT_W-1:0] nest_cnt
);

    typedef enum logic [1:0] {
        ST_NORM = 2'd0,
        ST_ERR  = 2'd1,
        ST_NEST = 2'd2
    } state_t;

    localparam logic [1:0] c_CODE_RST   = 2'd0;
    localparam logic [1:0] c_CODE_NMI   = 2'd1;
    localparam logic [1:0] c_CODE_CACHE = 2'd2;
    localparam logic [NEST_CNT_W-1:0] c_CNT_MAX = {NEST_CNT_W{1'b1}};

    state_t                r_state,       w_state_nxt;
    logic                  r_err_cap,     w_err_cap_nxt;
    logic                  r_nest_cap,    w_nest_cap_nxt;
    logic                  r_cap_bd,      w_cap_bd_nxt;
    logic                  r_redir_valid, w_redir_valid_nxt;
    logic [1:0]            r_redir_code,  w_redir_code_nxt;
    logic                  r_ret_sel,     w_ret_sel_nxt;
    logic [NEST_CNT_W-1:0] r_nest_cnt,    w_nest_cnt_nxt;

    logic                  w_sample;
    logic                  w_exc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_ERR;
            r_err_cap     <= 1'b0;
            r_nest_cap    <= 1'b0;
            r_cap_bd      <= 1'b0;
            r_redir_valid <= 1'b0;
            r_redir_code  <= c_CODE_RST;
            r_ret_sel     <= 1'b0;
            r_nest_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_err_cap     <= w_err_cap_nxt;
            r_nest_cap    <= w_nest_cap_nxt;
            r_cap_bd      <= w_cap_bd_nxt;
            r_redir_valid <= w_redir_valid_nxt;
            r_redir_code  <= w_redir_code_nxt;
            r_ret_sel     <= w_ret_sel_nxt;
            r_nest_cnt    <= w_nest_cnt_nxt;
        end
    end

    // The ack cycle is also a sampling cycle, which allows back-to-back redirects.
    assign w_sample = !r_redir_valid || redir_ack;
    assign w_exc    = soft_rst_req || nmi_req || cache_err_req;

    always_comb begin
        w_state_nxt       = r_state;
        w_err_cap_nxt     = 1'b0;
        w_nest_cap_nxt    = 1'b0;
        w_cap_bd_nxt      = r_cap_bd;
        w_redir_valid_nxt = r_redir_valid && !redir_ack;
        w_redir_code_nxt  = r_redir_code;
        w_ret_sel_nxt     = r_ret_sel;
        w_nest_cnt_nxt    = r_nest_cnt;

        if (w_sample && w_exc) begin
            w_redir_valid_nxt = 1'b1;
            w_ret_sel_nxt     = 1'b0;
            w_cap_bd_nxt      = bd_in;
            if (soft_rst_req)
                w_redir_code_nxt = c_CODE_RST;
            else if (nmi_req)
                w_redir_code_nxt = c_CODE_NMI;
            else
                w_redir_code_nxt = c_CODE_CACHE;

            case (r_state)
                ST_NORM: begin
                    w_err_cap_nxt = 1'b1;
                    w_state_nxt   = ST_ERR;
                end
                ST_ERR: begin
                    w_nest_cap_nxt = 1'b1;
                    w_state_nxt    = ST_NEST;
                    if (r_nest_cnt != c_CNT_MAX)
                        w_nest_cnt_nxt = r_nest_cnt + 1'b1;
                end
                ST_NEST: begin
                    // Third-level error: no EPC slot left, redirect only.
                    if (r_nest_cnt != c_CNT_MAX)
                        w_nest_cnt_nxt = r_nest_cnt + 1'b1;
                end
                default: w_state_nxt = ST_ERR;
            endcase
        end else if (soft_rst_req) begin
            // Soft reset pre-empts a pending redirect without a new capture.
            w_redir_code_nxt = c_CODE_RST;
            w_ret_sel_nxt    = 1'b0;
            w_state_nxt      = ST_ERR;
        end else if (w_sample && eret_req && (r_state != ST_NORM)) begin
            w_redir_valid_nxt = 1'b1;
            w_redir_code_nxt  = RET_VEC;
            w_ret_sel_nxt     = (r_state == ST_NEST);
            w_state_nxt       = (r_state == ST_NEST) ? ST_ERR : ST_NORM;
        end else if (sw_erl_we) begin
            if (!sw_erl_data)
                w_state_nxt = ST_NORM;
            else if (r_state == ST_NORM)
                w_state_nxt = ST_ERR;
        end
    end

    assign erl            = (r_state != ST_NORM);
    assign nested_erl     = (r_state == ST_NEST);
    assign err_epc_cap    = r_err_cap;
    assign nested_epc_cap = r_nest_cap;
    assign cap_bd         = r_cap_bd;
    assign redir_valid    = r_redir_valid;
    assign redir_code     = r_redir_code;
    assign ret_sel        = r_ret_sel;
    assign ev_stall       = r_redir_valid;
    assign nest_cnt       = r_nest_cnt;

endmodule
`default_nettype wire
